// File: rtl/reg_stack_sched_pkg.sv
// Shared types and defaults for the register-file write-port / call-stack scheduler.
// Imported by the scheduler top and its stack pointer counter.
package reg_stack_sched_pkg;

    localparam int REG_ADDR_W    = 3;
    localparam int DATA_W        = 32;
    localparam int PC_W          = 8;
    localparam int CNT_W         = 3;
    localparam int STACK_TOP_D   = 7;
    localparam int STACK_DEPTH_D = 4;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PUSH_WAIT = 2'd1,
        POP_RD    = 2'd2,
        POP_CLR   = 2'd3
    } state_t;

endpackage

// File: rtl/reg_stack_sched_stack_ptr_ctr.sv
// Stack occupancy counter; derives the next-free-slot pointer and full/empty.
// The stack grows downward from STACK_TOP.
module stack_ptr_ctr
    import reg_stack_sched_pkg::*;
#(
    parameter int STACK_TOP   = STACK_TOP_D,
    parameter int STACK_DEPTH = STACK_DEPTH_D
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  inc,
    input  logic                  dec,
    output logic [CNT_W-1:0]      count,
    output logic [REG_ADDR_W-1:0] sp,
    output logic                  full,
    output logic                  empty
);

    // Occupancy update; inc and dec are never raised together by the FSM.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (inc) begin
            count <= count + CNT_W'(1);
        end else if (dec) begin
            count <= count - CNT_W'(1);
        end
    end

    // Next free slot and occupancy flags from the counter.
    always_comb begin
        sp    = REG_ADDR_W'(STACK_TOP) - REG_ADDR_W'(count);
        full  = (count == CNT_W'(STACK_DEPTH));
        empty = (count == '0);
    end

endmodule

// File: rtl/reg_stack_sched.sv
// Arbitrates the register file write port between writeback and the call stack.
// Owns the stack FSM, stalls ID for unfinished stack ops and returns popped PCs.
module reg_stack_sched
    import reg_stack_sched_pkg::*;
#(
    parameter int STACK_TOP   = STACK_TOP_D,
    parameter int STACK_DEPTH = STACK_DEPTH_D
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  WB_regwrite,
    input  logic [REG_ADDR_W-1:0] WB_ws,
    input  logic [DATA_W-1:0]     WB_wd,
    input  logic                  ID_push,
    input  logic                  ID_pop,
    input  logic [PC_W-1:0]       stack_pc,
    input  logic [DATA_W-1:0]     rf_rdata,
    output logic                  rf_we,
    output logic [REG_ADDR_W-1:0] rf_ws,
    output logic [DATA_W-1:0]     rf_wd,
    output logic [REG_ADDR_W-1:0] rf_ra,
    output logic                  ID_stall,
    output logic [PC_W-1:0]       ret_pc,
    output logic                  ret_pc_valid,
    output logic                  stack_full,
    output logic                  stack_empty,
    output logic                  overflow_err,
    output logic                  underflow_err
);

    state_t                  state, state_nxt;
    logic [PC_W-1:0]         push_pc;
    logic [CNT_W-1:0]        count;
    logic [REG_ADDR_W-1:0]   sp;
    logic                    inc, dec;
    logic                    latch, cap, byp, pulse;
    logic                    set_ovf, set_unf;
    logic                    we_raw;

    stack_ptr_ctr #(
        .STACK_TOP   (STACK_TOP),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_ptr (
        .clk   (clk),
        .reset (reset),
        .inc   (inc),
        .dec   (dec),
        .count (count),
        .sp    (sp),
        .full  (stack_full),
        .empty (stack_empty)
    );

    // Next state, write-port mux and stall; writeback always owns the port when active.
    always_comb begin
        state_nxt = state;
        we_raw    = WB_regwrite;
        rf_ws     = WB_ws;
        rf_wd     = WB_wd;
        rf_ra     = sp + REG_ADDR_W'(1);
        ID_stall  = 1'b0;
        inc       = 1'b0;
        dec       = 1'b0;
        latch     = 1'b0;
        cap       = 1'b0;
        byp       = 1'b0;
        pulse     = 1'b0;
        set_ovf   = 1'b0;
        set_unf   = 1'b0;
        unique case (state)
            IDLE: begin
                if (ID_push && ID_pop) begin
                    byp = 1'b1;
                end else if (ID_push) begin
                    if (stack_full) begin
                        set_ovf = 1'b1;
                    end else if (!WB_regwrite) begin
                        we_raw = 1'b1;
                        rf_ws  = sp;
                        rf_wd  = {{(DATA_W-PC_W){1'b0}}, stack_pc};
                        inc    = 1'b1;
                    end else begin
                        latch     = 1'b1;
                        ID_stall  = 1'b1;
                        state_nxt = PUSH_WAIT;
                    end
                end else if (ID_pop) begin
                    if (stack_empty) begin
                        set_unf = 1'b1;
                    end else begin
                        ID_stall  = 1'b1;
                        state_nxt = POP_RD;
                    end
                end
            end
            PUSH_WAIT: begin
                if (WB_regwrite) begin
                    ID_stall = 1'b1;
                end else begin
                    we_raw    = 1'b1;
                    rf_ws     = sp;
                    rf_wd     = {{(DATA_W-PC_W){1'b0}}, push_pc};
                    inc       = 1'b1;
                    state_nxt = IDLE;
                end
            end
            POP_RD: begin
                ID_stall  = 1'b1;
                cap       = 1'b1;
                dec       = 1'b1;
                state_nxt = POP_CLR;
            end
            POP_CLR: begin
                ID_stall = 1'b1;
                if (!WB_regwrite) begin
                    we_raw    = 1'b1;
                    rf_ws     = sp;
                    rf_wd     = '0;
                    pulse     = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        rf_we = we_raw & reset;
    end

    // FSM state, pending push PC, return PC and sticky error flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            push_pc       <= '0;
            ret_pc        <= '0;
            ret_pc_valid  <= 1'b0;
            overflow_err  <= 1'b0;
            underflow_err <= 1'b0;
        end else begin
            state        <= state_nxt;
            ret_pc_valid <= pulse | byp;
            if (latch) begin
                push_pc <= stack_pc;
            end
            if (cap) begin
                ret_pc <= rf_rdata[PC_W-1:0];
            end else if (byp) begin
                ret_pc <= stack_pc;
            end
            if (set_ovf) begin
                overflow_err <= 1'b1;
            end
            if (set_unf) begin
                underflow_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_reg_stack_sched.sv
// Directed bench for reg_stack_sched with a behavioural 8x32 register file.
// Inputs change 1ns after rising edges; outputs are checked at falling edges or 1ns after rising edges.
module tb_reg_stack_sched;

    logic        clk = 1'b0;
    logic        reset;
    logic        WB_regwrite;
    logic [2:0]  WB_ws;
    logic [31:0] WB_wd;
    logic        ID_push;
    logic        ID_pop;
    logic [7:0]  stack_pc;
    logic [31:0] rf_rdata;
    logic        rf_we;
    logic [2:0]  rf_ws;
    logic [31:0] rf_wd;
    logic [2:0]  rf_ra;
    logic        ID_stall;
    logic [7:0]  ret_pc;
    logic        ret_pc_valid;
    logic        stack_full;
    logic        stack_empty;
    logic        overflow_err;
    logic        underflow_err;

    logic [31:0] regs [8];
    int          n_chk = 0;
    int          n_err = 0;

    reg_stack_sched dut (
        .clk           (clk),
        .reset         (reset),
        .WB_regwrite   (WB_regwrite),
        .WB_ws         (WB_ws),
        .WB_wd         (WB_wd),
        .ID_push       (ID_push),
        .ID_pop        (ID_pop),
        .stack_pc      (stack_pc),
        .rf_rdata      (rf_rdata),
        .rf_we         (rf_we),
        .rf_ws         (rf_ws),
        .rf_wd         (rf_wd),
        .rf_ra         (rf_ra),
        .ID_stall      (ID_stall),
        .ret_pc        (ret_pc),
        .ret_pc_valid  (ret_pc_valid),
        .stack_full    (stack_full),
        .stack_empty   (stack_empty),
        .overflow_err  (overflow_err),
        .underflow_err (underflow_err)
    );

    always #5 clk = ~clk;

    // Register file model: synchronous write, combinational read.
    always @(posedge clk) begin
        if (rf_we) regs[rf_ws] <= rf_wd;
    end
    assign rf_rdata = regs[rf_ra];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic mid;
        @(negedge clk);
    endtask

    task automatic idle_inputs;
        WB_regwrite = 1'b0;
        WB_ws       = '0;
        WB_wd       = '0;
        ID_push     = 1'b0;
        ID_pop      = 1'b0;
        stack_pc    = '0;
    endtask

    task automatic reset_dut;
        idle_inputs();
        WB_regwrite = 1'b1;
        WB_ws       = 3'd1;
        WB_wd       = 32'hdead;
        reset       = 1'b0;
        #1;
        chk("rst_we",    {31'b0, rf_we},         32'd0);
        chk("rst_empty", {31'b0, stack_empty},   32'd1);
        chk("rst_full",  {31'b0, stack_full},    32'd0);
        chk("rst_retpc", {24'b0, ret_pc},        32'd0);
        chk("rst_valid", {31'b0, ret_pc_valid},  32'd0);
        chk("rst_ovf",   {31'b0, overflow_err},  32'd0);
        chk("rst_unf",   {31'b0, underflow_err}, 32'd0);
        WB_regwrite = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        step();
    endtask

    task automatic push_free(input logic [7:0] pc, input logic [2:0] slot);
        ID_push  = 1'b1;
        stack_pc = pc;
        mid();
        chk("push_stall", {31'b0, ID_stall}, 32'd0);
        chk("push_ws",    {29'b0, rf_ws},    {29'b0, slot});
        step();
        ID_push = 1'b0;
        chk("push_reg",   regs[slot],        {24'b0, pc});
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        #2;
        reset_dut();

        // uncontended push
        push_free(8'h12, 3'd7);
        chk("p1_empty", {31'b0, stack_empty}, 32'd0);

        // push contended by two WB cycles
        ID_push     = 1'b1;
        stack_pc    = 8'h34;
        WB_regwrite = 1'b1;
        WB_ws       = 3'd2;
        WB_wd       = 32'd5;
        mid();
        chk("c1_stall", {31'b0, ID_stall}, 32'd1);
        chk("c1_ws",    {29'b0, rf_ws},    32'd2);
        chk("c1_wd",    rf_wd,             32'd5);
        step();
        chk("c1_reg2",  regs[2],           32'd5);
        mid();
        chk("c2_stall", {31'b0, ID_stall}, 32'd1);
        chk("c2_ws",    {29'b0, rf_ws},    32'd2);
        step();
        WB_regwrite = 1'b0;
        mid();
        chk("c3_stall", {31'b0, ID_stall}, 32'd0);
        chk("c3_ws",    {29'b0, rf_ws},    32'd6);
        chk("c3_wd",    rf_wd,             32'h34);
        step();
        ID_push = 1'b0;
        chk("c3_reg6",  regs[6],           32'h34);

        // pop 0x34
        ID_pop = 1'b1;
        mid();
        chk("pop0_ra",    {29'b0, rf_ra},    32'd6);
        chk("pop0_stall", {31'b0, ID_stall}, 32'd1);
        chk("pop0_we",    {31'b0, rf_we},    32'd0);
        step();
        mid();
        chk("pop1_ra",    {29'b0, rf_ra},    32'd6);
        chk("pop1_stall", {31'b0, ID_stall}, 32'd1);
        step();
        mid();
        chk("pop2_we",    {31'b0, rf_we},        32'd1);
        chk("pop2_ws",    {29'b0, rf_ws},        32'd6);
        chk("pop2_wd",    rf_wd,                 32'd0);
        chk("pop2_valid", {31'b0, ret_pc_valid}, 32'd0);
        step();
        ID_pop = 1'b0;
        chk("pop3_valid", {31'b0, ret_pc_valid}, 32'd1);
        chk("pop3_retpc", {24'b0, ret_pc},       32'h34);
        chk("pop3_reg6",  regs[6],               32'd0);
        chk("pop3_empty", {31'b0, stack_empty},  32'd0);
        step();
        chk("pop4_valid", {31'b0, ret_pc_valid}, 32'd0);
        // count is 1: next push lands in reg6
        push_free(8'h77, 3'd6);

        // fill and overflow
        reset_dut();
        for (int i = 1; i <= 4; i++) begin
            push_free(8'(i), 3'(8 - i));
        end
        chk("fill_full", {31'b0, stack_full}, 32'd1);
        ID_push  = 1'b1;
        stack_pc = 8'h05;
        mid();
        chk("ovf_we",    {31'b0, rf_we},        32'd0);
        chk("ovf_stall", {31'b0, ID_stall},     32'd0);
        step();
        ID_push = 1'b0;
        chk("ovf_err",   {31'b0, overflow_err}, 32'd1);
        chk("ovf_full",  {31'b0, stack_full},   32'd1);
        chk("ovf_reg4",  regs[4],               32'h04);
        step();
        chk("ovf_sticky", {31'b0, overflow_err}, 32'd1);

        // underflow then push+pop bypass
        reset_dut();
        ID_pop = 1'b1;
        mid();
        chk("unf_we",    {31'b0, rf_we},         32'd0);
        chk("unf_stall", {31'b0, ID_stall},      32'd0);
        step();
        ID_pop = 1'b0;
        chk("unf_err",   {31'b0, underflow_err}, 32'd1);
        chk("unf_valid", {31'b0, ret_pc_valid},  32'd0);
        ID_push  = 1'b1;
        ID_pop   = 1'b1;
        stack_pc = 8'h55;
        mid();
        chk("byp_we",    {31'b0, rf_we},        32'd0);
        chk("byp_stall", {31'b0, ID_stall},     32'd0);
        step();
        ID_push = 1'b0;
        ID_pop  = 1'b0;
        chk("byp_valid", {31'b0, ret_pc_valid}, 32'd1);
        chk("byp_retpc", {24'b0, ret_pc},       32'h55);
        chk("byp_empty", {31'b0, stack_empty},  32'd1);

        // reset during POP_CLR
        reset_dut();
        push_free(8'h12, 3'd7);
        ID_pop = 1'b1;
        step();
        step();
        WB_regwrite = 1'b1;
        WB_ws       = 3'd1;
        WB_wd       = 32'd9;
        mid();
        chk("ab_stall", {31'b0, ID_stall}, 32'd1);
        chk("ab_ws",    {29'b0, rf_ws},    32'd1);
        ID_pop = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        chk("ab_we",    {31'b0, rf_we},        32'd0);
        chk("ab_stall0", {31'b0, ID_stall},    32'd0);
        chk("ab_empty", {31'b0, stack_empty},  32'd1);
        chk("ab_retpc", {24'b0, ret_pc},       32'd0);
        chk("ab_valid", {31'b0, ret_pc_valid}, 32'd0);
        WB_regwrite = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        step();
        chk("ab_valid1", {31'b0, ret_pc_valid}, 32'd0);
        step();
        chk("ab_valid2", {31'b0, ret_pc_valid}, 32'd0);
        chk("ab_empty2", {31'b0, stack_empty},  32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
